// File: rtl/fifo_serial_out.sv
// fifo_serial_out
//   Output stage for the divider result path. Result words (data plus sign)
//   are buffered in a small synchronous FIFO. Each word is then sent as
//   SER_W-bit beats on a valid/ready channel, in the beat order set by
//   MSB_FIRST. When the last beat of one word is accepted, the next queued
//   word loads in the same cycle, so consecutive words leave with no gap.
//
// Ports
//   clk         rising-edge clock, the only clock
//   rst         synchronous active-high reset; discards any partly sent word
//   in_valid    input word valid
//   in_ready    FIFO can accept a word (low only while the FIFO is full)
//   in_data     word data, DATA_W bits
//   in_sign     word sign bit
//   out_valid   out_data holds a valid beat
//   out_ready   downstream accepts the current beat
//   out_data    current beat, SER_W bits
//   out_sign    sign of the word being sent; held for all of its beats
//   out_first   current beat is beat 0 of its word
//   out_last    current beat is the final beat of its word
//   fifo_count  words waiting in the FIFO; the word in the shifter is not counted
//
// Serialiser states
//   state  | meaning
//   S_IDLE | shifter empty; loads the FIFO head as soon as one is queued
//   S_SEND | shifter holds a word; out_valid is high and beats leave on out_ready

module fifo_serial_out #(
  parameter int DATA_W    = 64,
  parameter int SER_W     = 8,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SER_W-1:0]     out_data,
  output logic                 out_sign,
  output logic                 out_first,
  output logic                 out_last,
  output logic [LOG_DEPTH:0]   fifo_count
);

  localparam int NBEATS = DATA_W / SER_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [LOG_DEPTH:0] FULL_CNT  = (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // each FIFO entry is {sign, data}
  logic [DATA_W:0]      mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;

  logic [DATA_W-1:0]    ser;
  logic                 ser_sign;
  logic [CNT_W-1:0]     beat_cnt;

  logic wr_en;
  logic pop;
  logic fifo_nonempty;
  logic beat_last;
  logic beat_take;

  // in_ready comes from the count register only. A pop in the same cycle
  // does not reopen it, so there is no path from out_ready to in_ready.
  assign in_ready      = (fifo_count != FULL_CNT);
  assign wr_en         = in_valid && in_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign beat_last     = (beat_cnt == LAST_BEAT);
  assign beat_take     = (state == S_SEND) && out_ready;

  // Load the shifter when it is empty, or when its last beat is accepted,
  // so back-to-back words leave without a gap.
  assign pop = fifo_nonempty && ((state == S_IDLE) || (beat_take && beat_last));

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_sign, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + (LOG_DEPTH + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (LOG_DEPTH + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter, sign register and beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ser      <= '0;
      ser_sign <= 1'b0;
      beat_cnt <= '0;
    end else if (pop) begin
      ser      <= mem[rd_ptr][DATA_W-1:0];
      ser_sign <= mem[rd_ptr][DATA_W];
      beat_cnt <= '0;
    end else if (beat_take && !beat_last) begin
      // move the next beat toward the end out_data is taken from
      if (MSB_FIRST != 0) begin
        ser <= ser << SER_W;
      end else begin
        ser <= ser >> SER_W;
      end
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fifo_nonempty) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (beat_take && beat_last && !fifo_nonempty) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM: outputs
  // Every output is forced to zero outside S_SEND, which gives the all-zero
  // output state after reset. During a stall nothing here changes, because
  // the shifter and the counter only move on an accepted beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sign  = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (state == S_SEND) begin
      out_valid = 1'b1;
      if (MSB_FIRST != 0) begin
        out_data = ser[DATA_W-1 -: SER_W];
      end else begin
        out_data = ser[SER_W-1:0];
      end
      out_sign  = ser_sign;
      out_first = (beat_cnt == '0);
      out_last  = beat_last;
    end
  end

endmodule
